forward_unit_pipe: RTL

//  Parametrised operand-forwarding and load-use hazard unit for the pipelined MIPS core.

---
 rtl/forward_unit_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/forward_unit_pipe.sv
// Operand-forwarding and load-use hazard unit: tracks in-flight register writes in a
// STAGES-deep shift pipeline and serves NRD ID read ports. Optional counters: FWD_STATS_EN.
module forward_unit_pipe #(
  parameter int NRD    = 2,
  parameter int STAGES = 3,
  parameter int DW     = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  // Issue is a one-cycle strobe: an instruction enters slot 0 on a rising edge where
  // issue_valid & issue_we & !stall & !flush & !hold; there is no ready back-pressure.
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [AW-1:0]     issue_dreg,
  input  logic              issue_load,
  input  logic [DW-1:0]     exe_out,
  input  logic [DW-1:0]     mem_out,
  input  logic [NRD*AW-1:0] id_reg,
  input  logic [NRD*DW-1:0] id_out,
  output logic [NRD*DW-1:0] id_exe_reg,
  output logic [NRD-1:0]    fwd_hit,
`ifdef FWD_STATS_EN
  output logic [31:0]       stat_fwd,
  output logic [31:0]       stat_stall,
`endif
  output logic              stall
);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] load_q;
  logic [AW-1:0]     dreg_q [STAGES];
  logic [DW-1:0]     data_q [STAGES];
  logic [DW-1:0]     data_adv [STAGES];
  logic              issue_ok;

  assign issue_ok = issue_valid & issue_we & ~stall & ~flush & (issue_dreg != '0);

  // Data each slot carries forward on advance: slot 0 ALU results and slot 1 load
  // data are only valid on the live inputs, so they are captured as they leave.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      data_adv[s] = data_q[s];
      if (s == 0 && !load_q[0]) data_adv[s] = exe_out;
      if (s == 1 && load_q[1])  data_adv[s] = mem_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      load_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dreg_q[s] <= '0;
        data_q[s] <= '0;
      end
    end else if (flush) begin
      v_q <= '0;
    end else if (!hold) begin
      v_q       <= {v_q[STAGES-2:0], issue_ok};
      load_q    <= {load_q[STAGES-2:0], issue_load};
      dreg_q[0] <= issue_dreg;
      data_q[0] <= '0;
      for (int s = 1; s < STAGES; s++) begin
        dreg_q[s] <= dreg_q[s-1];
        data_q[s] <= data_adv[s-1];
      end
    end
  end

  logic [AW-1:0] rsel;
  logic [DW-1:0] fval;
  logic          fhit;
  logic          fld0;

  // Scan oldest to youngest so the youngest matching slot overrides.
  always_comb begin
    id_exe_reg = id_out;
    fwd_hit    = '0;
    stall      = 1'b0;
    rsel       = '0;
    fval       = '0;
    fhit       = 1'b0;
    fld0       = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      rsel = id_reg[p*AW +: AW];
      fval = id_out[p*DW +: DW];
      fhit = 1'b0;
      fld0 = 1'b0;
      for (int s = STAGES - 1; s >= 0; s--) begin
        if (v_q[s] && dreg_q[s] == rsel && rsel != '0) begin
          fhit = 1'b1;
          fld0 = 1'b0;
          if (s == 0 && load_q[0]) begin
            fhit = 1'b0;
            fld0 = 1'b1;
            fval = id_out[p*DW +: DW];
          end else if (s == 0) begin
            fval = exe_out;
          end else if (s == 1 && load_q[1]) begin
            fval = mem_out;
          end else begin
            fval = data_q[s];
          end
        end
      end
      id_exe_reg[p*DW +: DW] = fval;
      fwd_hit[p]             = fhit;
      stall                  = stall | fld0;
    end
  end

`ifdef FWD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fwd   <= '0;
      stat_stall <= '0;
    end else if (!hold) begin
      if (|fwd_hit && stat_fwd != 32'hFFFF_FFFF) stat_fwd <= stat_fwd + 32'd1;
      if (stall && stat_stall != 32'hFFFF_FFFF)  stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
